full_event_monitor: RTL and testbench
=====================================

Name: full_event_monitor

Overview:
- Downstream consumer of the 2-bit synchronous counter's terminal flag (FULL).
- Detects each rising edge of FULL as one wrap event and accumulates events into batches of programmable size.
- Raises a level interrupt (IRQ) when a batch completes, then holds it until acknowledged.
- Counts events missed while the interrupt is pending, and keeps a saturating lifetime total.

Parameters:
- CNT_W, 8: width of the batch counter and of THRESH_IN.
- TOT_W, 16: width of the lifetime total counter.
- MISS_W, 4: width of the missed-event counter.

Ports:
- CLK  input  1  rising-edge clock, same domain as the upstream counter.
- RESET_N  input  1  asynchronous, active-low reset.
- FULL_IN  input  1  FULL output of the upstream counter; registered, synchronous to CLK, no synchronizer.
- ARM  input  1  level; 1 = collect batches, 0 = stop collecting.
- ACK  input  1  single-cycle pulse; acknowledges IRQ, ignored outside PEND.
- THRESH_IN  input  CNT_W  batch size; sampled on entry to ACCUM; value 0 is treated as 1.
- BATCH_CNT  output  CNT_W  events in the current batch.
- TOTAL_CNT  output  TOT_W  events detected while in ACCUM or PEND; saturates at all ones.
- MISSED  output  MISS_W  events detected during PEND; saturates at all ones.
- OVERFLOW  output  1  equals (MISSED != 0).
- IRQ  output  1  high exactly while in PEND.
- STATE  output  2  encoding IDLE=0, ACCUM=1, PEND=2.

Behaviour:
- Reset (RESET_N=0, asynchronous):
  - state=IDLE; full_d=0; thr=0.
  - BATCH_CNT=0, TOTAL_CNT=0, MISSED=0, IRQ=0, OVERFLOW=0.
- Edge detect:
  - ev = FULL_IN & ~full_d; full_d <= FULL_IN every cycle.
  - FULL_IN held high (upstream ENABLE=0 at count 3) yields exactly one event.
  - Back-to-back wraps (FULL_IN high 1 of every 4 cycles) yield one event per wrap.
- Latency: ev at edge k updates counters, state and IRQ at edge k; outputs are registered and visible after edge k.
- IDLE:
  - ev is ignored; no counters change.
  - ARM=1: BATCH_CNT<=0, MISSED<=0, thr<=max(THRESH_IN,1), go to ACCUM.
- ACCUM:
  - ARM=0 has priority: go to IDLE, BATCH_CNT holds, any ev that cycle is dropped.
  - Otherwise on ev: TOTAL_CNT++ (saturating).
    - If BATCH_CNT+1 == thr: BATCH_CNT<=thr, go to PEND (IRQ=1).
    - Else BATCH_CNT<=BATCH_CNT+1.
- PEND:
  - ev without ACK: TOTAL_CNT++ and MISSED++ (both saturating); BATCH_CNT holds at thr.
  - ACK (any ARM):
    - MISSED<=0; thr is re-sampled from THRESH_IN (0 treated as 1).
    - ARM=1: go to ACCUM; BATCH_CNT<=0, or 1 if ev in the same cycle (that event starts the new batch and is not counted as missed).
    - ARM=0: go to IDLE; BATCH_CNT<=0; a same-cycle ev is dropped.
    - ACK+ev+ARM=1 with new thr=1: BATCH_CNT<=1 and state goes straight back to PEND (IRQ stays high).
  - ARM=0 without ACK: stay in PEND; IRQ must be acknowledged first.
- Width rules:
  - All counters are unsigned and never wrap.
  - TOTAL_CNT and MISSED hold at all ones; BATCH_CNT never exceeds thr.
- Reset mid-batch or mid-PEND: immediate return to reset values; a pending IRQ is lost.
- STATE value 3 is unreachable; if entered, next edge goes to IDLE.

Test Plan:
- Reset, ARM=1, THRESH_IN=4, counter free-running (FULL every 4th cycle) → IRQ rises at the edge of the 4th FULL rise; BATCH_CNT=4, TOTAL_CNT=4, STATE=2.
- FULL_IN held high 10 cycles in ACCUM (thr=4) → BATCH_CNT increments once only, from 0 to 1.
- In PEND, 3 further FULL rises, then ACK → before ACK: MISSED=3, OVERFLOW=1, TOTAL_CNT=7; after ACK: MISSED=0, OVERFLOW=0, BATCH_CNT=0, STATE=1.
- ACK coincident with a FULL rise, ARM=1 → BATCH_CNT=1, MISSED unchanged by that event, TOTAL_CNT+1, IRQ=0.
- THRESH_IN=0 → IRQ on the first FULL rise; ACK with ev in the same cycle → IRQ stays high, BATCH_CNT=1.
- Drop RESET_N while in PEND with MISSED=2 → immediately IRQ=0, all counters 0, STATE=0; FULL rises in IDLE leave TOTAL_CNT=0.

Source files
------------

// File: rtl/full_event_monitor_if.sv
// Bus between the upstream wrap source / host and the full event monitor.
// The master side drives FULL_IN, ARM, ACK and THRESH_IN; the monitor is the slave.
interface full_event_monitor_if #(
  parameter int CNT_W  = 8,
  parameter int TOT_W  = 16,
  parameter int MISS_W = 4
);
  logic              FULL_IN;
  logic              ARM;
  logic              ACK;
  logic [CNT_W-1:0]  THRESH_IN;
  logic [CNT_W-1:0]  BATCH_CNT;
  logic [TOT_W-1:0]  TOTAL_CNT;
  logic [MISS_W-1:0] MISSED;
  logic              OVERFLOW;
  logic              IRQ;
  logic [1:0]        STATE;

  modport master (
    output FULL_IN, ARM, ACK, THRESH_IN,
    input  BATCH_CNT, TOTAL_CNT, MISSED, OVERFLOW, IRQ, STATE
  );

  modport slave (
    input  FULL_IN, ARM, ACK, THRESH_IN,
    output BATCH_CNT, TOTAL_CNT, MISSED, OVERFLOW, IRQ, STATE
  );
endinterface

// File: rtl/full_event_monitor.sv
// Full event monitor: turns rising edges of the upstream counter's FULL flag
// into wrap events, groups them into batches of programmable size, raises a
// level IRQ per completed batch and tracks missed events and a lifetime total.
module full_event_monitor #(
  parameter int CNT_W  = 8,
  parameter int TOT_W  = 16,
  parameter int MISS_W = 4
) (
  input logic                CLK,
  input logic                RESET_N,
  full_event_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_PEND  = 2'd2
  } state_t;

  state_t              state_q, state_nx;
  logic                full_d;
  logic [CNT_W-1:0]    thr_q, thr_nx;
  logic [CNT_W-1:0]    batch_q, batch_nx;
  logic [TOT_W-1:0]    tot_q, tot_nx;
  logic [MISS_W-1:0]   miss_q, miss_nx;
  logic                ev;
  logic [CNT_W-1:0]    thr_in_eff;
  logic [CNT_W:0]      batch_inc;

  // Counters hold at all ones instead of wrapping.
  function automatic logic [TOT_W-1:0] sat_inc_tot(input logic [TOT_W-1:0] v);
    return (&v) ? v : v + {{(TOT_W-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [MISS_W-1:0] sat_inc_miss(input logic [MISS_W-1:0] v);
    return (&v) ? v : v + {{(MISS_W-1){1'b0}}, 1'b1};
  endfunction

  // A zero batch size would never complete, so it is promoted to one.
  function automatic logic [CNT_W-1:0] thr_clamp(input logic [CNT_W-1:0] v);
    return (v == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : v;
  endfunction

  assign ev         = mon.FULL_IN & ~full_d;
  assign thr_in_eff = thr_clamp(mon.THRESH_IN);
  // One bit wider so the compare against thr cannot alias on overflow.
  assign batch_inc  = {1'b0, batch_q} + {{CNT_W{1'b0}}, 1'b1};

  // State and counter registers; reset discards any pending batch or IRQ.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= S_IDLE;
      full_d  <= 1'b0;
      thr_q   <= '0;
      batch_q <= '0;
      tot_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_nx;
      full_d  <= mon.FULL_IN;
      thr_q   <= thr_nx;
      batch_q <= batch_nx;
      tot_q   <= tot_nx;
      miss_q  <= miss_nx;
    end
  end

  // Next-state and counter update; ARM drop in ACCUM and ACK in PEND take priority over events.
  always_comb begin
    state_nx = state_q;
    thr_nx   = thr_q;
    batch_nx = batch_q;
    tot_nx   = tot_q;
    miss_nx  = miss_q;
    case (state_q)
      S_IDLE: begin
        if (mon.ARM) begin
          batch_nx = '0;
          miss_nx  = '0;
          thr_nx   = thr_in_eff;
          state_nx = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (!mon.ARM) begin
          state_nx = S_IDLE;
        end else if (ev) begin
          tot_nx = sat_inc_tot(tot_q);
          if (batch_inc == {1'b0, thr_q}) begin
            batch_nx = thr_q;
            state_nx = S_PEND;
          end else begin
            batch_nx = batch_inc[CNT_W-1:0];
          end
        end
      end
      S_PEND: begin
        if (mon.ACK) begin
          miss_nx = '0;
          thr_nx  = thr_in_eff;
          if (mon.ARM) begin
            if (ev) begin
              // The coincident event opens the new batch rather than being missed.
              tot_nx   = sat_inc_tot(tot_q);
              batch_nx = {{(CNT_W-1){1'b0}}, 1'b1};
              state_nx = (thr_in_eff == {{(CNT_W-1){1'b0}}, 1'b1}) ? S_PEND : S_ACCUM;
            end else begin
              batch_nx = '0;
              state_nx = S_ACCUM;
            end
          end else begin
            batch_nx = '0;
            state_nx = S_IDLE;
          end
        end else if (ev) begin
          tot_nx  = sat_inc_tot(tot_q);
          miss_nx = sat_inc_miss(miss_q);
        end
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign mon.BATCH_CNT = batch_q;
  assign mon.TOTAL_CNT = tot_q;
  assign mon.MISSED    = miss_q;
  assign mon.OVERFLOW  = (miss_q != '0);
  assign mon.IRQ       = (state_q == S_PEND);
  assign mon.STATE     = state_q;

endmodule

// File: tb/tb_full_event_monitor.sv
// Testbench for full_event_monitor: scenario tasks queue stimulus and the
// expected post-edge outputs, then drain the queues comparing cycle by cycle.
module tb_full_event_monitor;

  logic CLK = 1'b0;
  logic RESET_N;

  full_event_monitor_if #(.CNT_W(8), .TOT_W(16), .MISS_W(4)) bus ();

  full_event_monitor #(.CNT_W(8), .TOT_W(16), .MISS_W(4)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .mon     (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [7:0]  b;
    logic [15:0] t;
    logic [3:0]  m;
    logic        o;
    logic        i;
    logic [1:0]  s;
  } obs_t;

  typedef struct {
    logic       full;
    logic       arm;
    logic       ack;
    logic [7:0] th;
    string      name;
  } step_t;

  step_t stim[$];
  obs_t  sb[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  function automatic obs_t mk(input int b, input int t, input int m, input int s);
    obs_t r;
    r.b = 8'(b);
    r.t = 16'(t);
    r.m = 4'(m);
    r.o = (m != 0);
    r.i = (s == 2);
    r.s = 2'(s);
    return r;
  endfunction

  function automatic obs_t cur();
    obs_t r;
    r.b = bus.BATCH_CNT;
    r.t = bus.TOTAL_CNT;
    r.m = bus.MISSED;
    r.o = bus.OVERFLOW;
    r.i = bus.IRQ;
    r.s = bus.STATE;
    return r;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic f, input logic a, input logic k, input logic [7:0] th,
                      input obs_t e, input string nm);
    step_t s;
    s.full = f; s.arm = a; s.ack = k; s.th = th; s.name = nm;
    stim.push_back(s);
    sb.push_back(e);
  endtask

  // One upstream wrap: FULL high for one cycle out of four.
  task automatic push_wrap(input logic a, input logic [7:0] th, input obs_t e, input string nm);
    push(1'b1, a, 1'b0, th, e, nm);
    repeat (3) push(1'b0, a, 1'b0, th, e, nm);
  endtask

  task automatic test_reset();
    obs_t e, g;
    RESET_N = 1'b0;
    bus.FULL_IN = 1'b0; bus.ARM = 1'b1; bus.ACK = 1'b0; bus.THRESH_IN = 8'd4;
    #2;
    e = mk(0, 0, 0, 0);
    g = cur();
    n_chk++;
    if (g !== e) begin n_fail++; $display("FAIL reset_async: got=%p want=%p", g, e); end
    bus.FULL_IN = 1'b1;
    tick();
    bus.FULL_IN = 1'b0;
    tick();
    g = cur();
    n_chk++;
    if (g !== e) begin n_fail++; $display("FAIL reset_held: got=%p want=%p", g, e); end
    bus.ARM = 1'b0;
    RESET_N = 1'b1;
  endtask

  task automatic test_batch();
    step_t s; obs_t e, g;
    push(1'b0, 1'b1, 1'b0, 8'd4, mk(0, 0, 0, 1), "arm_accum");
    for (int k = 1; k <= 4; k++) push_wrap(1'b1, 8'd4, mk(k, k, 0, (k == 4) ? 2 : 1), "batch_wrap");
    for (int k = 1; k <= 3; k++) push_wrap(1'b1, 8'd4, mk(4, 4 + k, k, 2), "pend_missed");
    push(1'b0, 1'b1, 1'b1, 8'd4, mk(0, 7, 0, 1), "ack_rearm");
    while (stim.size() > 0) begin
      s = stim.pop_front();
      bus.FULL_IN = s.full; bus.ARM = s.arm; bus.ACK = s.ack; bus.THRESH_IN = s.th;
      tick();
      e = sb.pop_front();
      g = cur();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL %s: got=%p want=%p", s.name, g, e); end
    end
  endtask

  task automatic test_held_full();
    step_t s; obs_t e, g;
    repeat (10) push(1'b1, 1'b1, 1'b0, 8'd4, mk(1, 8, 0, 1), "held_full");
    push(1'b0, 1'b1, 1'b0, 8'd4, mk(1, 8, 0, 1), "held_release");
    while (stim.size() > 0) begin
      s = stim.pop_front();
      bus.FULL_IN = s.full; bus.ARM = s.arm; bus.ACK = s.ack; bus.THRESH_IN = s.th;
      tick();
      e = sb.pop_front();
      g = cur();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL %s: got=%p want=%p", s.name, g, e); end
    end
  endtask

  task automatic test_ack_with_event();
    step_t s; obs_t e, g;
    push_wrap(1'b1, 8'd4, mk(2, 9, 0, 1), "refill");
    push_wrap(1'b1, 8'd4, mk(3, 10, 0, 1), "refill");
    push_wrap(1'b1, 8'd4, mk(4, 11, 0, 2), "refill_irq");
    push_wrap(1'b1, 8'd4, mk(4, 12, 1, 2), "pend_missed1");
    push(1'b1, 1'b1, 1'b1, 8'd4, mk(1, 13, 0, 1), "ack_same_ev");
    repeat (3) push(1'b0, 1'b1, 1'b0, 8'd4, mk(1, 13, 0, 1), "ack_same_ev_hold");
    while (stim.size() > 0) begin
      s = stim.pop_front();
      bus.FULL_IN = s.full; bus.ARM = s.arm; bus.ACK = s.ack; bus.THRESH_IN = s.th;
      tick();
      e = sb.pop_front();
      g = cur();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL %s: got=%p want=%p", s.name, g, e); end
    end
  endtask

  task automatic test_thresh_zero();
    step_t s; obs_t e, g;
    push(1'b0, 1'b0, 1'b0, 8'd0, mk(1, 13, 0, 0), "disarm_idle");
    push(1'b0, 1'b1, 1'b0, 8'd0, mk(0, 13, 0, 1), "arm_thr0");
    push_wrap(1'b1, 8'd0, mk(1, 14, 0, 2), "thr0_irq");
    push(1'b1, 1'b1, 1'b1, 8'd0, mk(1, 15, 0, 2), "thr0_ack_ev");
    push(1'b0, 1'b1, 1'b0, 8'd0, mk(1, 15, 0, 2), "thr0_still_pend");
    push(1'b0, 1'b0, 1'b0, 8'd0, mk(1, 15, 0, 2), "disarm_no_ack");
    push(1'b1, 1'b0, 1'b1, 8'd0, mk(0, 15, 0, 0), "ack_disarm_drop");
    push(1'b0, 1'b0, 1'b0, 8'd0, mk(0, 15, 0, 0), "idle_settle");
    push_wrap(1'b0, 8'd0, mk(0, 15, 0, 0), "idle_ignore");
    while (stim.size() > 0) begin
      s = stim.pop_front();
      bus.FULL_IN = s.full; bus.ARM = s.arm; bus.ACK = s.ack; bus.THRESH_IN = s.th;
      tick();
      e = sb.pop_front();
      g = cur();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL %s: got=%p want=%p", s.name, g, e); end
    end
  endtask

  task automatic test_miss_saturate();
    step_t s; obs_t e, g;
    push(1'b0, 1'b1, 1'b0, 8'd1, mk(0, 15, 0, 1), "arm_thr1");
    push_wrap(1'b1, 8'd1, mk(1, 16, 0, 2), "thr1_irq");
    for (int k = 1; k <= 17; k++) push_wrap(1'b1, 8'd1, mk(1, 16 + k, (k > 15) ? 15 : k, 2), "miss_sat");
    push(1'b0, 1'b0, 1'b1, 8'd1, mk(0, 33, 0, 0), "ack_to_idle");
    while (stim.size() > 0) begin
      s = stim.pop_front();
      bus.FULL_IN = s.full; bus.ARM = s.arm; bus.ACK = s.ack; bus.THRESH_IN = s.th;
      tick();
      e = sb.pop_front();
      g = cur();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL %s: got=%p want=%p", s.name, g, e); end
    end
  endtask

  task automatic test_reset_in_pend();
    step_t s; obs_t e, g;
    push(1'b0, 1'b1, 1'b0, 8'd1, mk(0, 33, 0, 1), "rp_arm");
    push_wrap(1'b1, 8'd1, mk(1, 34, 0, 2), "rp_irq");
    push_wrap(1'b1, 8'd1, mk(1, 35, 1, 2), "rp_miss1");
    push_wrap(1'b1, 8'd1, mk(1, 36, 2, 2), "rp_miss2");
    while (stim.size() > 0) begin
      s = stim.pop_front();
      bus.FULL_IN = s.full; bus.ARM = s.arm; bus.ACK = s.ack; bus.THRESH_IN = s.th;
      tick();
      e = sb.pop_front();
      g = cur();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL %s: got=%p want=%p", s.name, g, e); end
    end
    #2;
    RESET_N = 1'b0;
    #1;
    e = mk(0, 0, 0, 0);
    g = cur();
    n_chk++;
    if (g !== e) begin n_fail++; $display("FAIL reset_mid_pend: got=%p want=%p", g, e); end
    tick();
    bus.ARM = 1'b0;
    RESET_N = 1'b1;
    push(1'b0, 1'b0, 1'b0, 8'd1, mk(0, 0, 0, 0), "post_reset_idle");
    push_wrap(1'b0, 8'd1, mk(0, 0, 0, 0), "post_reset_ignore");
    push_wrap(1'b0, 8'd1, mk(0, 0, 0, 0), "post_reset_ignore");
    while (stim.size() > 0) begin
      s = stim.pop_front();
      bus.FULL_IN = s.full; bus.ARM = s.arm; bus.ACK = s.ack; bus.THRESH_IN = s.th;
      tick();
      e = sb.pop_front();
      g = cur();
      n_chk++;
      if (g !== e) begin n_fail++; $display("FAIL %s: got=%p want=%p", s.name, g, e); end
    end
  endtask

  initial begin
    test_reset();
    test_batch();
    test_held_full();
    test_ack_with_event();
    test_thresh_zero();
    test_miss_saturate();
    test_reset_in_pend();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
